ps2_kbd_rx: RTL

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

---
 rtl/ps2_kbd_rx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes the raw bus, decodes 11-bit frames and
// queues good scan bytes in a 4-entry FIFO with an AXI-Stream style output.
//
// state  | meaning
// IDLE   | waiting for a start bit (fall with dat=0)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit, then push or report an error
module ps2_kbd_rx #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] output_axis_tdata,
   output logic       output_axis_tvalid,
   input  logic       output_axis_tready,
   output logic       busy,
   output logic       parity_error,
   output logic       frame_error,
   output logic       overrun_error
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        clk_s1_q, clk_s1_d;
   logic        clk_s2_q, clk_s2_d;
   logic        clk_prev_q, clk_prev_d;
   logic        dat_s1_q, dat_s1_d;
   logic        dat_s2_q, dat_s2_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_acc_q, par_acc_d;
   logic        par_ok_q, par_ok_d;
   logic [15:0] to_cnt_q, to_cnt_d;
   logic        parity_error_q, parity_error_d;
   logic        frame_error_q, frame_error_d;
   logic        overrun_error_q, overrun_error_d;
   logic [7:0]  mem_q [4];
   logic [7:0]  mem_d [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  fifo_cnt_q, fifo_cnt_d;

   logic fall;
   logic push_req;
   logic push;
   logic pop;
   logic full;

   assign fall = clk_prev_q & ~clk_s2_q;

   always_comb begin
      clk_s1_d        = ps2_clk;
      clk_s2_d        = clk_s1_q;
      clk_prev_d      = clk_s2_q;
      dat_s1_d        = ps2_dat;
      dat_s2_d        = dat_s1_q;
      state_d         = state_q;
      bit_cnt_d       = bit_cnt_q;
      shift_d         = shift_q;
      par_acc_d       = par_acc_q;
      par_ok_d        = par_ok_q;
      to_cnt_d        = to_cnt_q;
      parity_error_d  = 1'b0;
      frame_error_d   = 1'b0;
      push_req        = 1'b0;

      case (state_q)
         IDLE: begin
            if (fall && !dat_s2_q) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
               par_acc_d = 1'b0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_d[bit_cnt_q] = dat_s2_q;
               par_acc_d          = par_acc_q ^ dat_s2_q;
               bit_cnt_d          = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
               par_ok_d = par_acc_q ^ dat_s2_q;
               state_d  = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_d = IDLE;
               if (!dat_s2_q)      frame_error_d  = 1'b1;
               else if (!par_ok_q) parity_error_d = 1'b1;
               else                push_req       = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Stall guard: a frame whose clock stops is abandoned as a framing error.
      if (state_q == IDLE || fall) begin
         to_cnt_d = 16'd0;
      end else if (to_cnt_q >= TIMEOUT_CYCLES) begin
         to_cnt_d      = 16'd0;
         state_d       = IDLE;
         frame_error_d = 1'b1;
      end else begin
         to_cnt_d = to_cnt_q + 16'd1;
      end
   end

   assign full = (fifo_cnt_q == 3'd4);
   assign pop  = (fifo_cnt_q != 3'd0) && output_axis_tready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push = push_req && (!full || pop);

   always_comb begin
      mem_d           = mem_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      fifo_cnt_d      = fifo_cnt_q;
      overrun_error_d = push_req && full && !pop;
      if (push) begin
         mem_d[wr_ptr_q] = shift_q;
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
      if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 3'd1;
      else if (pop && !push) fifo_cnt_d = fifo_cnt_q - 3'd1;
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         clk_s1_q        <= 1'b1;
         clk_s2_q        <= 1'b1;
         clk_prev_q      <= 1'b1;
         dat_s1_q        <= 1'b1;
         dat_s2_q        <= 1'b1;
         state_q         <= IDLE;
         bit_cnt_q       <= 3'd0;
         shift_q         <= 8'h00;
         par_acc_q       <= 1'b0;
         par_ok_q        <= 1'b0;
         to_cnt_q        <= 16'd0;
         parity_error_q  <= 1'b0;
         frame_error_q   <= 1'b0;
         overrun_error_q <= 1'b0;
         for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
         wr_ptr_q        <= 2'd0;
         rd_ptr_q        <= 2'd0;
         fifo_cnt_q      <= 3'd0;
      end else begin
         clk_s1_q        <= clk_s1_d;
         clk_s2_q        <= clk_s2_d;
         clk_prev_q      <= clk_prev_d;
         dat_s1_q        <= dat_s1_d;
         dat_s2_q        <= dat_s2_d;
         state_q         <= state_d;
         bit_cnt_q       <= bit_cnt_d;
         shift_q         <= shift_d;
         par_acc_q       <= par_acc_d;
         par_ok_q        <= par_ok_d;
         to_cnt_q        <= to_cnt_d;
         parity_error_q  <= parity_error_d;
         frame_error_q   <= frame_error_d;
         overrun_error_q <= overrun_error_d;
         mem_q           <= mem_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         fifo_cnt_q      <= fifo_cnt_d;
      end
   end

   assign output_axis_tvalid = (fifo_cnt_q != 3'd0);
   assign output_axis_tdata  = output_axis_tvalid ? mem_q[rd_ptr_q] : 8'h00;
   assign busy               = (state_q != IDLE);
   assign parity_error       = parity_error_q;
   assign frame_error        = frame_error_q;
   assign overrun_error      = overrun_error_q;

endmodule
